watermark_block_engine: RTL and testbench
=========================================

WATERMARK_BLOCK_ENGINE -- requirements
Module: watermark_block_engine

Interface
REQ-001 Parameter DATA_DEPTH, 8, pixel and header word width in bits.
REQ-002 Parameter MAX_BLOCK_DIM, 72, maximum block side M; the buffers SHALL hold MAX_BLOCK_DIM^2 pixels each.
REQ-003 Parameter COEF_FRAC, 7, fractional bits of the ak/bk coefficients (unsigned Q(DATA_DEPTH-COEF_FRAC).COEF_FRAC).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  when low, state, counters and outputs SHALL hold and in_ready SHALL be 0.
REQ-007 in_data  input  DATA_DEPTH  header word or pixel.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block accepts in_data; a word transfers when in_valid&in_ready&en.
REQ-010 out_data  output  DATA_DEPTH  blended pixel.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts out_data.
REQ-013 out_last  output  1  high with the final pixel of a block.
REQ-014 done  output  1  one-cycle pulse after the final pixel transfers.
REQ-015 hdr_err  output  1  one-cycle pulse on an illegal header.

Function
REQ-016 States: IDLE, HDR, LOAD_P, LOAD_W, CALC, EMIT; IDLE SHALL move to HDR on the first cycle with en high.
REQ-017 HDR SHALL accept 6 words in order: M, Bthr, A_min, A_max, B_min, B_max, then enter LOAD_P.
REQ-018 If the accepted M is 0 or greater than MAX_BLOCK_DIM, the next cycle SHALL pulse hdr_err and return to IDLE.
REQ-019 LOAD_P SHALL accept M*M primary pixels in raster order, then LOAD_W SHALL accept M*M watermark pixels; in_ready SHALL be 1 only in HDR, LOAD_P and LOAD_W.
REQ-020 During LOAD_P: sigma_M accumulates each pixel; sigma_G accumulates |P[r][c]-P[r][c-1]| for c>0; both SHALL be cleared on entry to HDR and sized so that no overflow occurs at MAX_BLOCK_DIM.
REQ-021 CALC SHALL last exactly DATA_DEPTH+1 cycles: DATA_DEPTH cycles of restoring division mean = floor(sigma_M/(M*M)), then 1 cycle of coefficient update; in_ready and out_valid are 0.
REQ-022 Texture test: if sigma_G >= Bthr*M*(M-1), then ak=A_max and bk=B_min.
REQ-023 Otherwise, with d=|mean - 2^(DATA_DEPTH-1)| clamped to 2^(DATA_DEPTH-1)-1: ak = A_min + (((A_max-A_min)*d) >> (DATA_DEPTH-1)) and bk = B_max - (((B_max-B_min)*d) >> (DATA_DEPTH-1)).
REQ-024 If A_min>A_max, ak SHALL be A_min; if B_min>B_max, bk SHALL be B_max (no wrap in the subtractions).
REQ-025 For M=1 the threshold product is 0; the texture test then passes for any Bthr, since sigma_G=0.
REQ-026 EMIT SHALL output M*M pixels in raster order, each equal to (ak*P[i]+bk*W[i]) >> COEF_FRAC, computed without truncation before the shift.
REQ-027 out_data and out_last SHALL stay stable while out_valid&!out_ready; the first out_valid SHALL occur no later than 2 cycles after CALC ends.
REQ-028 The cycle after the out_last transfer, done SHALL pulse and the FSM SHALL enter IDLE.

Reset
REQ-029 On rst low, in any state including mid-load or mid-emit, the FSM SHALL enter IDLE, clear all counters and accumulators, and discard the partial block.
REQ-030 Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, done=0, hdr_err=0; buffer contents are undefined.

Configuration
REQ-031 With macro WM_OUT_SATURATE_EN defined, a blend result above 2^DATA_DEPTH-1 SHALL output 2^DATA_DEPTH-1.
REQ-032 Without WM_OUT_SATURATE_EN, the output SHALL be the low DATA_DEPTH bits of the blend result.

Verification (DATA_DEPTH=8, COEF_FRAC=7)
REQ-033 Flat block: header M=2,Bthr=10,32,96,16,64; P all 128, W all 200 -> ak=32, bk=64, four outputs of 132, out_last on the 4th, done one cycle later.
REQ-034 Texture block: same header, P={0,255,0,255}, W all 0 -> sigma_G=510>=20, ak=96, outputs {0,191,0,191}.
REQ-035 Overflow: header M=2,Bthr=255,255,255,255,255; P=W all 255 -> raw 1016; output 255 with WM_OUT_SATURATE_EN, 248 without.
REQ-036 Header error: M=0 -> hdr_err pulse, no out_valid, the next legal header is processed normally; repeat with M=73.
REQ-037 Backpressure and stall: hold out_ready low 3 cycles mid-EMIT and en low 2 cycles mid-LOAD_P -> out_data stable, no pixel lost or duplicated.
REQ-038 Reset mid-LOAD_W: drop rst for 1 cycle -> all outputs 0 and IDLE; a fresh block after reset gives the REQ-033 results.

Source files
------------

// File: rtl/watermark_block_engine_if.sv
//==============================================================================
// watermark_block_engine_if: pixel input stream and blended output stream.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface watermark_block_engine_if #(
  parameter int DATA_DEPTH = 8
);
  logic [DATA_DEPTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_DEPTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

`default_nettype wire

// File: rtl/watermark_block_engine.sv
//==============================================================================
// watermark_block_engine: adaptive-strength watermark blend over MxM blocks.
// Define WM_OUT_SATURATE_EN to clamp blend results instead of wrapping them.
// Revision: 1.0
//==============================================================================
`default_nettype none

module watermark_block_engine #(
  parameter int DATA_DEPTH    = 8,
  parameter int MAX_BLOCK_DIM = 72,
  parameter int COEF_FRAC     = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  watermark_block_engine_if.slave        bus,
  output logic                           done,
  output logic                           hdr_err
);

  localparam int c_depth = MAX_BLOCK_DIM * MAX_BLOCK_DIM;
  localparam int c_idx_w = $clog2(c_depth);
  localparam int c_sum_w = $clog2(c_depth * ((1 << DATA_DEPTH) - 1) + 1);
  localparam int c_div_w = c_sum_w + DATA_DEPTH;
  localparam int c_sq_w  = 2 * DATA_DEPTH;
  localparam int c_thr_w = 3 * DATA_DEPTH;
  localparam int c_cmp_w = c_sum_w + c_thr_w;
  localparam int c_cnt_w = $clog2(DATA_DEPTH + 1);
  localparam int c_bl_w  = 2 * DATA_DEPTH + 1;

  localparam logic [31:0]           c_max_m    = MAX_BLOCK_DIM;
  localparam logic [c_cnt_w-1:0]    c_div_last = c_cnt_w'(DATA_DEPTH);
  localparam logic [c_cnt_w-1:0]    c_sh_top   = c_cnt_w'(DATA_DEPTH - 1);
  localparam logic [DATA_DEPTH-1:0] c_half     = DATA_DEPTH'(1 << (DATA_DEPTH - 1));

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD_P, S_LOAD_W, S_CALC, S_EMIT} state_t;

  state_t                r_state, w_state_nx;
  logic [2:0]            r_hdr_cnt;
  logic [DATA_DEPTH-1:0] r_m, r_bthr, r_amin, r_amax, r_bmin, r_bmax;
  logic [c_sq_w-1:0]     r_npix;
  logic [c_idx_w-1:0]    r_last, r_wr_idx, r_out_idx;
  logic [DATA_DEPTH-1:0] r_col, r_prev;
  logic [c_sum_w-1:0]    r_sig_m, r_sig_g, r_rem;
  logic [DATA_DEPTH-1:0] r_q, r_ak, r_bk;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_out_valid, r_done, r_hdr_err;
  logic [DATA_DEPTH-1:0] r_p_rd, r_w_rd;

  logic [DATA_DEPTH-1:0] p_mem [c_depth];
  logic [DATA_DEPTH-1:0] w_mem [c_depth];

  logic                  w_in_ready, w_in_fire, w_out_fire, w_out_last, w_m_bad;
  logic [DATA_DEPTH-1:0] w_absdiff;
  logic [c_cnt_w-1:0]    w_shamt;
  logic [c_div_w-1:0]    w_trial, w_rem_ext;
  logic                  w_take;
  logic [c_sum_w-1:0]    w_rem_nx;
  logic [c_thr_w-1:0]    w_thr;
  logic                  w_textured;
  logic [DATA_DEPTH-1:0] w_d_raw, w_d, w_a_adj, w_b_adj, w_ak, w_bk;
  logic [c_sq_w-1:0]     w_a_prod, w_b_prod;
  logic [c_bl_w-1:0]     w_blend;
  logic [DATA_DEPTH-1:0] w_pix;
  logic                  w_rd_en;
  logic [c_idx_w-1:0]    w_rd_addr;

  assign w_in_ready = en && (r_state inside {S_HDR, S_LOAD_P, S_LOAD_W});
  assign w_in_fire  = w_in_ready && bus.in_valid;
  assign w_out_fire = en && r_out_valid && bus.out_ready;
  assign w_out_last = r_out_valid && (r_out_idx == r_last);
  assign w_m_bad    = (bus.in_data == '0) || (32'(bus.in_data) > c_max_m);
  assign w_absdiff  = (bus.in_data >= r_prev) ? bus.in_data - r_prev : r_prev - bus.in_data;

  // Restoring division: one quotient bit per cycle, MSB first, shifting the divisor.
  assign w_shamt   = c_sh_top - r_cnt;
  assign w_trial   = c_div_w'(r_npix) << w_shamt;
  assign w_rem_ext = c_div_w'(r_rem);
  assign w_take    = (w_rem_ext >= w_trial);
  assign w_rem_nx  = c_sum_w'(w_rem_ext - w_trial);

  assign w_thr      = c_thr_w'(r_bthr) * c_thr_w'(r_m) * c_thr_w'(r_m - 1'b1);
  assign w_textured = (c_cmp_w'(r_sig_g) >= c_cmp_w'(w_thr));
  assign w_d_raw    = (r_q >= c_half) ? r_q - c_half : c_half - r_q;
  assign w_d        = (w_d_raw > c_half - 1'b1) ? c_half - 1'b1 : w_d_raw;
  assign w_a_prod   = c_sq_w'(r_amax - r_amin) * c_sq_w'(w_d);
  assign w_b_prod   = c_sq_w'(r_bmax - r_bmin) * c_sq_w'(w_d);
  assign w_a_adj    = DATA_DEPTH'(w_a_prod >> (DATA_DEPTH - 1));
  assign w_b_adj    = DATA_DEPTH'(w_b_prod >> (DATA_DEPTH - 1));
  assign w_ak = w_textured ? r_amax : ((r_amin > r_amax) ? r_amin : r_amin + w_a_adj);
  assign w_bk = w_textured ? r_bmin : ((r_bmin > r_bmax) ? r_bmax : r_bmax - w_b_adj);

  assign w_blend = c_bl_w'(r_ak) * c_bl_w'(r_p_rd) + c_bl_w'(r_bk) * c_bl_w'(r_w_rd);
`ifdef WM_OUT_SATURATE_EN
  logic [c_bl_w-COEF_FRAC-1:0] w_raw;
  assign w_raw = (c_bl_w-COEF_FRAC)'(w_blend >> COEF_FRAC);
  assign w_pix = (|w_raw[c_bl_w-COEF_FRAC-1:DATA_DEPTH]) ? '1 : w_raw[DATA_DEPTH-1:0];
`else
  assign w_pix = DATA_DEPTH'(w_blend >> COEF_FRAC);
`endif

  // Output operands only move on a transfer, so out_data holds under backpressure.
  assign w_rd_en   = en && (((r_state == S_CALC) && (r_cnt == c_div_last)) ||
                            ((r_state == S_EMIT) && w_out_fire && !w_out_last));
  assign w_rd_addr = (r_state == S_CALC) ? '0 : r_out_idx + 1'b1;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_last  = w_out_last;
  assign bus.out_data  = r_out_valid ? w_pix : '0;
  assign done          = r_done;
  assign hdr_err       = r_hdr_err;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   w_state_nx = S_HDR;
      S_HDR: begin
        if (w_in_fire) begin
          if ((r_hdr_cnt == 3'd0) && w_m_bad) w_state_nx = S_IDLE;
          else if (r_hdr_cnt == 3'd5)         w_state_nx = S_LOAD_P;
        end
      end
      S_LOAD_P: if (w_in_fire && (r_wr_idx == r_last)) w_state_nx = S_LOAD_W;
      S_LOAD_W: if (w_in_fire && (r_wr_idx == r_last)) w_state_nx = S_CALC;
      S_CALC:   if (r_cnt == c_div_last) w_state_nx = S_EMIT;
      S_EMIT:   if (w_out_fire && w_out_last) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    r_state <= S_IDLE;
    else if (en) r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hdr_cnt <= '0;  r_m <= '0;    r_bthr <= '0;
      r_amin <= '0;     r_amax <= '0; r_bmin <= '0;  r_bmax <= '0;
      r_npix <= '0;     r_last <= '0; r_wr_idx <= '0; r_out_idx <= '0;
      r_col <= '0;      r_prev <= '0; r_sig_m <= '0; r_sig_g <= '0;
      r_rem <= '0;      r_q <= '0;    r_ak <= '0;    r_bk <= '0;
      r_cnt <= '0;      r_out_valid <= 1'b0;
      r_done <= 1'b0;   r_hdr_err <= 1'b0;
    end else if (en) begin
      r_done    <= (r_state == S_EMIT) && w_out_fire && w_out_last;
      r_hdr_err <= (r_state == S_HDR) && w_in_fire && (r_hdr_cnt == 3'd0) && w_m_bad;
      case (r_state)
        S_IDLE: begin
          r_hdr_cnt <= '0; r_sig_m <= '0; r_sig_g <= '0; r_wr_idx <= '0;
          r_col <= '0;     r_cnt <= '0;   r_out_idx <= '0;
        end
        S_HDR: if (w_in_fire) begin
          r_hdr_cnt <= r_hdr_cnt + 3'd1;
          case (r_hdr_cnt)
            3'd0: begin
              r_m    <= bus.in_data;
              r_npix <= c_sq_w'(bus.in_data) * c_sq_w'(bus.in_data);
              r_last <= c_idx_w'(c_sq_w'(bus.in_data) * c_sq_w'(bus.in_data) - 1'b1);
            end
            3'd1:    r_bthr <= bus.in_data;
            3'd2:    r_amin <= bus.in_data;
            3'd3:    r_amax <= bus.in_data;
            3'd4:    r_bmin <= bus.in_data;
            default: r_bmax <= bus.in_data;
          endcase
        end
        S_LOAD_P: if (w_in_fire) begin
          r_sig_m <= r_sig_m + c_sum_w'(bus.in_data);
          if (r_col != '0) r_sig_g <= r_sig_g + c_sum_w'(w_absdiff);
          r_prev   <= bus.in_data;
          r_col    <= (r_col == r_m - 1'b1) ? '0 : r_col + 1'b1;
          r_wr_idx <= (r_wr_idx == r_last) ? '0 : r_wr_idx + 1'b1;
        end
        S_LOAD_W: if (w_in_fire) begin
          if (r_wr_idx == r_last) begin
            r_wr_idx <= '0;
            r_rem    <= r_sig_m;
            r_q      <= '0;
            r_cnt    <= '0;
          end else begin
            r_wr_idx <= r_wr_idx + 1'b1;
          end
        end
        S_CALC: begin
          if (r_cnt != c_div_last) begin
            r_cnt <= r_cnt + 1'b1;
            r_q   <= {r_q[DATA_DEPTH-2:0], w_take};
            if (w_take) r_rem <= w_rem_nx;
          end else begin
            r_ak        <= w_ak;
            r_bk        <= w_bk;
            r_out_idx   <= '0;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_EMIT: if (w_out_fire) begin
          if (w_out_last) r_out_valid <= 1'b0;
          else            r_out_idx   <= r_out_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire && (r_state == S_LOAD_P)) p_mem[r_wr_idx] <= bus.in_data;
    if (w_in_fire && (r_state == S_LOAD_W)) w_mem[r_wr_idx] <= bus.in_data;
    if (w_rd_en) begin
      r_p_rd <= p_mem[w_rd_addr];
      r_w_rd <= w_mem[w_rd_addr];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_watermark_block_engine.sv
//==============================================================================
// tb_watermark_block_engine: directed and randomized blocks against a block-level model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_watermark_block_engine;
  localparam int DD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic done;
  logic hdr_err;

  int total = 0;
  int bad   = 0;
  int pq[$];
  int wq[$];
  int eq[$];

  watermark_block_engine_if #(.DATA_DEPTH(DD)) bus ();

  watermark_block_engine #(
    .DATA_DEPTH(DD), .MAX_BLOCK_DIM(72), .COEF_FRAC(7)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .done(done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input int v);
    int guard;
    bit fired;
    guard = 0;
    bus.in_data  = DD'(v);
    bus.in_valid = 1'b1;
    forever begin
      #1;
      fired = bus.in_ready && en;
      tick();
      if (fired) break;
      guard++;
      if (guard > 1000) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic stall_en(input int v);
    en           = 1'b0;
    bus.in_data  = DD'(v);
    bus.in_valid = 1'b1;
    repeat (2) begin
      #1;
      check("stall_in_ready", bus.in_ready, 0);
      tick();
    end
    en = 1'b1;
  endtask

  task automatic send_header(input int m, input int bt, input int a0, input int a1,
                             input int b0, input int b1);
    send_word(m);  send_word(bt); send_word(a0);
    send_word(a1); send_word(b0); send_word(b1);
  endtask

  task automatic drain(input int stall_at, input bit rnd);
    int i, n, guard, stalls;
    bit rdy, v;
    n = eq.size(); i = 0; guard = 0; stalls = 0;
    while (i < n) begin
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (i == stall_at && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end
      bus.out_ready = rdy;
      #1;
      v = bus.out_valid;
      if (v) begin
        check($sformatf("out_data[%0d]", i), bus.out_data, eq[i]);
        check($sformatf("out_last[%0d]", i), bus.out_last, int'(i == n - 1));
      end
      tick();
      if (v && rdy) i++;
      guard++;
      if (guard > 8 * n + 100) begin
        check("drain_timeout", i, n);
        break;
      end
    end
    bus.out_ready = 1'b0;
    if (i == n) begin
      check("done_pulse", done, 1);
      check("valid_after_last", bus.out_valid, 0);
      tick();
      check("done_clears", done, 0);
    end
  endtask

  task automatic xfer(input int m, input int bt, input int a0, input int a1,
                      input int b0, input int b1, input int p_stall,
                      input int o_stall, input bit rnd);
    send_header(m, bt, a0, a1, b0, b1);
    for (int k = 0; k < pq.size(); k++) begin
      if (k == p_stall) stall_en(pq[k]);
      send_word(pq[k]);
    end
    for (int k = 0; k < wq.size(); k++) send_word(wq[k]);
    drain(o_stall, rnd);
  endtask

  // Block-level reference: statistics, strength coefficients, then per-pixel blend.
  task automatic model(input int m, input int bt, input int a0, input int a1,
                       input int b0, input int b1);
    int sm, sg, mean, d, ak, bk, raw;
    sm = 0; sg = 0;
    for (int k = 0; k < pq.size(); k++) begin
      sm += pq[k];
      if (k % m != 0) sg += (pq[k] > pq[k-1]) ? pq[k] - pq[k-1] : pq[k-1] - pq[k];
    end
    mean = sm / (m * m);
    if (sg >= bt * m * (m - 1)) begin
      ak = a1; bk = b0;
    end else begin
      d = (mean >= 128) ? mean - 128 : 128 - mean;
      if (d > 127) d = 127;
      ak = (a0 > a1) ? a0 : a0 + (((a1 - a0) * d) / 128);
      bk = (b0 > b1) ? b1 : b1 - (((b1 - b0) * d) / 128);
    end
    eq.delete();
    for (int k = 0; k < pq.size(); k++) begin
      raw = (ak * pq[k] + bk * wq[k]) / 128;
`ifdef WM_OUT_SATURATE_EN
      eq.push_back((raw > 255) ? 255 : raw);
`else
      eq.push_back(raw % 256);
`endif
    end
  endtask

  task automatic flat_block();
    pq = '{128, 128, 128, 128};
    wq = '{200, 200, 200, 200};
    eq = '{132, 132, 132, 132};
    xfer(2, 10, 32, 96, 16, 64, 1, 2, 1'b0);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_in_ready"},  bus.in_ready,  0);
    check({pfx, "_out_valid"}, bus.out_valid, 0);
    check({pfx, "_out_last"},  bus.out_last,  0);
    check({pfx, "_out_data"},  bus.out_data,  0);
    check({pfx, "_done"},      done,          0);
    check({pfx, "_hdr_err"},   hdr_err,       0);
  endtask

  initial begin
    int m, bt, a0, a1, b0, b1;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    en  = 1'b1;

    flat_block();

    pq = '{0, 255, 0, 255};
    wq = '{0, 0, 0, 0};
    eq = '{0, 191, 0, 191};
    xfer(2, 10, 32, 96, 16, 64, -1, -1, 1'b1);

    pq = '{255, 255, 255, 255};
    wq = '{255, 255, 255, 255};
`ifdef WM_OUT_SATURATE_EN
    eq = '{255, 255, 255, 255};
`else
    eq = '{248, 248, 248, 248};
`endif
    xfer(2, 255, 255, 255, 255, 255, -1, -1, 1'b0);

    send_word(0);
    check("hdr_err_m0", hdr_err, 1);
    check("hdr_err_m0_valid", bus.out_valid, 0);
    tick();
    check("hdr_err_m0_clears", hdr_err, 0);
    flat_block();

    send_word(73);
    check("hdr_err_m73", hdr_err, 1);
    check("hdr_err_m73_valid", bus.out_valid, 0);
    tick();
    check("hdr_err_m73_clears", hdr_err, 0);
    flat_block();

    send_header(2, 10, 32, 96, 16, 64);
    for (int k = 0; k < 4; k++) send_word(128);
    send_word(200);
    send_word(200);
    rst = 1'b0;
    #1;
    check_idle_outputs("midload_reset");
    tick();
    rst = 1'b1;
    flat_block();

    for (int b = 0; b < 7; b++) begin
      m  = (b == 0) ? 1 : $urandom_range(2, 6);
      bt = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom_range(100, 255);
      a0 = $urandom_range(0, 255); a1 = $urandom_range(0, 255);
      b0 = $urandom_range(0, 255); b1 = $urandom_range(0, 255);
      pq.delete(); wq.delete();
      for (int k = 0; k < m * m; k++) begin
        pq.push_back((b % 2 == 0) ? $urandom_range(0, 255) : $urandom_range(90, 110));
        wq.push_back($urandom_range(0, 255));
      end
      model(m, bt, a0, a1, b0, b1);
      xfer(m, bt, a0, a1, b0, b1, -1, -1, 1'b1);
    end

    m = 72; bt = 255; a0 = 20; a1 = 200; b0 = 10; b1 = 150;
    pq.delete(); wq.delete();
    for (int k = 0; k < m * m; k++) begin
      pq.push_back($urandom_range(0, 63));
      wq.push_back($urandom_range(0, 255));
    end
    model(m, bt, a0, a1, b0, b1);
    xfer(m, bt, a0, a1, b0, b1, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
